premuat3_inv_pipe: RTL

Pipelined inverse of the stage-3 coefficient permutation in the tq path. It takes one 32-lane row per beat, in the butterfly-reordered lane order produced by the forward permutation, and restores natural coefficient order for the given transform size. The row is carried through three registered merge stages under a valid/ready handshake. It sits between the column/row transform datapath and the downstream quant/transpose stages, so reordered rows return to natural order before leaving the transform.

---
 rtl/premuat3_inv_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/premuat3_inv_pipe.sv
// premuat3_inv_pipe: restores natural lane order of a stage-3 reordered row.
// Three elastic stages undo the merge32, merge16 and merge8 permutations.
module premuat3_inv_pipe #(
    parameter int WIDTH = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_in_ready,
    input  logic [1:0]         i_transize,
    input  logic [32*WIDTH-1:0] i_data,
    output logic               o_valid,
    input  logic               i_out_ready,
    output logic [1:0]         o_transize,
    output logic [32*WIDTH-1:0] o_data
);

    typedef logic [31:0][WIDTH-1:0] row_t;

    // Interleave the two halves of an (2*h)-lane group starting at base.
    function automatic row_t merge(
        input row_t       d,
        input logic [4:0] base,
        input int         h
    );
        row_t       r;
        logic [4:0] e;
        r = d;
        for (int k = 0; k < h; k++) begin
            e = base + 5'(2 * k);
            r[e] = d[base + 5'(k)];
            r[e + 5'd1] = d[base + 5'(h + k)];
        end
        return r;
    endfunction

    row_t       w_in;
    row_t       w_a_nxt;
    row_t       w_b_nxt;
    row_t       w_c_nxt;
    logic       w_rdy_b;
    logic       w_rdy_c;

    logic       r_a_vld;
    logic [1:0] r_a_sz;
    row_t       r_a_dat;
    logic       r_b_vld;
    logic [1:0] r_b_sz;
    row_t       r_b_dat;
    logic       r_c_vld;
    logic [1:0] r_c_sz;
    row_t       r_c_dat;

    assign w_in = i_data;

    // Backpressure ripples back from the output; never looks at i_valid.
    assign w_rdy_c    = !r_c_vld || i_out_ready;
    assign w_rdy_b    = !r_b_vld || w_rdy_c;
    assign o_in_ready = !r_a_vld || w_rdy_b;

    // Stage A permutation: full-row merge for 32-point rows only.
    always_comb begin
        w_a_nxt = w_in;
        if (i_transize == 2'b11) begin
            w_a_nxt = merge(w_in, 5'd0, 16);
        end
    end

    // Stage B permutation: lower half for 16/32, upper half for 16 only.
    always_comb begin
        w_b_nxt = r_a_dat;
        if (r_a_sz[1]) begin
            w_b_nxt = merge(w_b_nxt, 5'd0, 8);
        end
        if (r_a_sz == 2'b10) begin
            w_b_nxt = merge(w_b_nxt, 5'd16, 8);
        end
    end

    // Stage C permutation: per-group 8-lane merges depending on size.
    always_comb begin
        w_c_nxt = r_b_dat;
        if (r_b_sz != 2'b00) begin
            w_c_nxt = merge(w_c_nxt, 5'd0, 4);
        end
        if (r_b_sz == 2'b01) begin
            w_c_nxt = merge(w_c_nxt, 5'd8, 4);
            w_c_nxt = merge(w_c_nxt, 5'd24, 4);
        end
        if (r_b_sz == 2'b01 || r_b_sz == 2'b10) begin
            w_c_nxt = merge(w_c_nxt, 5'd16, 4);
        end
    end

    // Stage A register: captures a row on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vld <= 1'b0;
            r_a_sz  <= '0;
            r_a_dat <= '0;
        end else if (o_in_ready) begin
            r_a_vld <= i_valid;
            if (i_valid) begin
                r_a_sz  <= i_transize;
                r_a_dat <= w_a_nxt;
            end
        end
    end

    // Stage B register: advances when stage C can take a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_vld <= 1'b0;
            r_b_sz  <= '0;
            r_b_dat <= '0;
        end else if (w_rdy_b) begin
            r_b_vld <= r_a_vld;
            if (r_a_vld) begin
                r_b_sz  <= r_a_sz;
                r_b_dat <= w_b_nxt;
            end
        end
    end

    // Stage C register: output stage, holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_vld <= 1'b0;
            r_c_sz  <= '0;
            r_c_dat <= '0;
        end else if (w_rdy_c) begin
            r_c_vld <= r_b_vld;
            if (r_b_vld) begin
                r_c_sz  <= r_b_sz;
                r_c_dat <= w_c_nxt;
            end
        end
    end

    assign o_valid    = r_c_vld;
    assign o_transize = r_c_sz;
    assign o_data     = r_c_dat;

endmodule
